// File: rtl/msdf_cmp_feeder_pkg.sv
// Purpose: shared constants for the MSDF comparator feeder (digit codes, result codes, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   SD_*       signed-digit encodings, 2 bits per digit (00/11 both mean zero)
//   CMP_*      one-hot comparator result codes, CMP_NONE used on timeout
//   ST_*       feeder FSM state encodings
//   res_flags_t  captured comparator verdict (code + error flag)
//   is_onehot3   true when a 3-bit result code is a legal verdict
package msdf_cmp_feeder_pkg;

  // Signed-digit encodings. 2'b00 and 2'b11 both decode to zero.
  localparam logic [1:0] SD_PLUS1  = 2'b10;
  localparam logic [1:0] SD_MINUS1 = 2'b01;
  localparam logic [1:0] SD_ZERO   = 2'b00;

  // Comparator verdicts, one-hot.
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  // Feeder FSM states.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STREAM = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  typedef struct packed {
    logic [2:0] cmp;
    logic       err;
  } res_flags_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == CMP_GT) || (v == CMP_EQ) || (v == CMP_LT);
  endfunction

endpackage

// File: rtl/msdf_digit_shifter.sv
// Purpose: loadable left-shift register pair presenting the most significant digit of x and y.
// Latency: load visible on the outputs one cycle after i_load; each i_shift advances one digit.
// Backpressure: none; the owner decides when to shift.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_load               capture i_x / i_y (has priority over i_shift)
//   i_shift              move both registers one digit towards the MSD end
//   i_x, i_y             packed operands, 2 bits/digit, MSD in the top bits
//   o_dig_x, o_dig_y     current top digit of each register
module msdf_digit_shifter #(
  parameter int DIGITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [2*DIGITS-1:0]   i_x,
  input  logic [2*DIGITS-1:0]   i_y,
  output logic [1:0]            o_dig_x,
  output logic [1:0]            o_dig_y
);

  logic [2*DIGITS-1:0] sh_x;
  logic [2*DIGITS-1:0] sh_y;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sh_x <= '0;
      sh_y <= '0;
    end else if (i_load) begin
      sh_x <= i_x;
      sh_y <= i_y;
    end else if (i_shift) begin
      // Zeros fill from the bottom, so an over-shift emits zero digits.
      sh_x <= sh_x << 2;
      sh_y <= sh_y << 2;
    end
  end

  assign o_dig_x = sh_x[2*DIGITS-1 -: 2];
  assign o_dig_y = sh_y[2*DIGITS-1 -: 2];

endmodule

// File: rtl/msdf_cmp_feeder.sv
// Purpose: streams two signed-digit operands MSD-first into an online comparator and returns its verdict.
// Latency: first digit 1 cycle after operand accept; result >= DIGITS + GAP_CYCLES cycles after accept.
// Backpressure: one operand in flight; o_op_ready only in IDLE, result held in HOLD until i_res_ready.
//
// Ports:
//   i_clk, i_rstn                      clock (rising edge), asynchronous active-low reset
//   i_op_x, i_op_y, i_op_err_limit     operand payload, accepted on i_op_valid & o_op_ready
//   o_mbus_wen/wvalid/wlast            comparator write strobes, high only while streaming
//   o_mbus_wdata_x/y                   current digit pair (zero outside STREAM)
//   o_mbus_werr_limit                  error limit latched at operand accept
//   i_mbus_rdata, i_mbus_rvalid        comparator verdict (one-hot) and its strobe
//   o_res_cmp/digits/err               captured verdict, digit pairs sent, error flag
//   o_res_valid, i_res_ready           result handshake
module msdf_cmp_feeder
  import msdf_cmp_feeder_pkg::*;
#(
  parameter int DIGITS     = 16,
  parameter int ERR_WIDTH  = 8,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [2*DIGITS-1:0]           i_op_x,
  input  logic [2*DIGITS-1:0]           i_op_y,
  input  logic [ERR_WIDTH-1:0]          i_op_err_limit,
  input  logic                          i_op_valid,
  output logic                          o_op_ready,
  output logic                          o_mbus_wen,
  output logic                          o_mbus_wvalid,
  output logic                          o_mbus_wlast,
  output logic [ERR_WIDTH-1:0]          o_mbus_werr_limit,
  output logic [1:0]                    o_mbus_wdata_x,
  output logic [1:0]                    o_mbus_wdata_y,
  input  logic [2:0]                    i_mbus_rdata,
  input  logic                          i_mbus_rvalid,
  output logic [2:0]                    o_res_cmp,
  output logic [$clog2(DIGITS+1)-1:0]   o_res_digits,
  output logic                          o_res_err,
  output logic                          o_res_valid,
  input  logic                          i_res_ready
);

  localparam int DCW = $clog2(DIGITS + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  // +2 keeps the width non-zero even when GAP_CYCLES is 0.
  localparam int GCW = $clog2(GAP_CYCLES + 2);

  localparam logic [DCW-1:0] DIG_MAX  = DCW'(DIGITS);
  localparam logic [DCW-1:0] DIG_LAST = DCW'(DIGITS - 1);
  localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT - 1);
  // A zero-length gap still spends one cycle in GAP so rvalid can be watched.
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [DCW-1:0]       dig_cnt;     // digits already sent before this cycle
  logic [DCW-1:0]       dig_inc;     // digits sent including this cycle (saturating)
  logic [TCW-1:0]       to_cnt;
  logic [GCW-1:0]       gap_cnt;
  logic [ERR_WIDTH-1:0] err_lim;
  res_flags_t           res_q;
  logic [DCW-1:0]       res_digits_q;

  logic                 op_xfer;
  logic                 in_stream;
  logic                 last_dig;
  logic                 to_expire;
  logic                 gap_done;
  logic [1:0]           dig_x;
  logic [1:0]           dig_y;

  assign op_xfer   = i_op_valid && (state == ST_IDLE);
  assign in_stream = (state == ST_STREAM);
  assign last_dig  = in_stream && (dig_cnt == DIG_LAST);
  assign to_expire = (state == ST_WAIT) && (to_cnt == TO_LAST);
  assign gap_done  = (gap_cnt >= GAP_LAST);
  assign dig_inc   = (dig_cnt == DIG_MAX) ? DIG_MAX : dig_cnt + 1'b1;

  msdf_digit_shifter #(
    .DIGITS (DIGITS)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_load  (op_xfer),
    .i_shift (in_stream),
    .i_x     (i_op_x),
    .i_y     (i_op_y),
    .o_dig_x (dig_x),
    .o_dig_y (dig_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_op_valid) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        // An early verdict wins over the final digit.
        if (i_mbus_rvalid)  state_nxt = ST_GAP;
        else if (last_dig)  state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mbus_rvalid || to_expire) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        // Do not present the result while the comparator still drives rvalid.
        if (gap_done && !i_mbus_rvalid) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= ST_IDLE;
      dig_cnt      <= '0;
      to_cnt       <= '0;
      gap_cnt      <= '0;
      err_lim      <= '0;
      res_q        <= '0;
      res_digits_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (op_xfer) begin
            dig_cnt <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            err_lim <= i_op_err_limit;
          end
        end
        ST_STREAM: begin
          dig_cnt <= dig_inc;
          if (i_mbus_rvalid) begin
            res_q.cmp    <= i_mbus_rdata;
            res_q.err    <= !is_onehot3(i_mbus_rdata);
            // The digit on the bus this cycle was written, so it counts.
            res_digits_q <= dig_inc;
          end
        end
        ST_WAIT: begin
          if (i_mbus_rvalid) begin
            res_q.cmp    <= i_mbus_rdata;
            res_q.err    <= !is_onehot3(i_mbus_rdata);
            res_digits_q <= dig_cnt;
          end else if (to_expire) begin
            res_q.cmp    <= CMP_NONE;
            res_q.err    <= 1'b1;
            res_digits_q <= dig_cnt;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset removes them in the same cycle.
  assign o_op_ready        = (state == ST_IDLE);
  assign o_mbus_wen        = in_stream;
  assign o_mbus_wvalid     = in_stream;
  assign o_mbus_wlast      = last_dig;
  assign o_mbus_wdata_x    = in_stream ? dig_x : SD_ZERO;
  assign o_mbus_wdata_y    = in_stream ? dig_y : SD_ZERO;
  assign o_mbus_werr_limit = err_lim;

  assign o_res_cmp    = res_q.cmp;
  assign o_res_err    = res_q.err;
  assign o_res_digits = res_digits_q;
  assign o_res_valid  = (state == ST_HOLD);

endmodule

// File: doc/msdf_cmp_feeder.md
MSDF_CMP_FEEDER -- requirements
Module: msdf_cmp_feeder

Interface
REQ-001 Parameter DIGITS, default 16: operand length in signed-digit positions.
REQ-002 Parameter ERR_WIDTH, default 8: width of the error-limit field.
REQ-003 Parameter TIMEOUT, default 16: maximum WAIT cycles for a comparator result.
REQ-004 Parameter GAP_CYCLES, default 2: minimum idle cycles between bursts.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_op_x  in  2*DIGITS  operand x, packed 2 bits/digit, MSD in the top bits.
- i_op_y  in  2*DIGITS  operand y, same packing.
- i_op_err_limit  in  ERR_WIDTH  error limit forwarded to the comparator.
- i_op_valid / o_op_ready  in / out  1  operand handshake.
- o_mbus_wen, o_mbus_wvalid, o_mbus_wlast  out  1  comparator write strobes.
- o_mbus_werr_limit  out  ERR_WIDTH  latched error limit.
- o_mbus_wdata_x / o_mbus_wdata_y  out  2  current digit pair.
- i_mbus_rdata  in  3  comparator result, one-hot.
- i_mbus_rvalid  in  1  comparator result valid.
- o_res_cmp  out  3  captured result: 100 means x>y, 010 means x==y, 001 means x<y.
- o_res_digits  out  clog2(DIGITS+1)  digit pairs sent.
- o_res_err  out  1  timeout or non-one-hot result.
- o_res_valid / i_res_ready  out / in  1  result handshake.

Function
REQ-006 Digit encoding SHALL be: 10 = +1, 01 = -1, 00 and 11 = 0.
REQ-007 The FSM SHALL have five states: IDLE, STREAM, WAIT, GAP, HOLD.
REQ-008 o_op_ready SHALL be 1 only in IDLE.
REQ-009 An operand transfer occurs on i_op_valid & o_op_ready. On a transfer the block SHALL latch x, y and err_limit, clear the digit counter, and enter STREAM.
REQ-010 In STREAM, each cycle SHALL drive one digit pair MSD-first, with o_mbus_wen = o_mbus_wvalid = 1 and no bubbles.
REQ-011 The first digit SHALL appear the cycle after the operand transfer.
REQ-012 o_mbus_wlast SHALL be 1 only with the digit DIGITS-1 position counted from the MSD, i.e. the final digit.
REQ-013 After the final digit, the next cycle SHALL enter WAIT with wen, wvalid and wlast at 0.
REQ-014 Early abort: i_mbus_rvalid=1 in STREAM SHALL capture the result, set o_res_digits to the digits sent so far, drop wen/wvalid the next cycle, and enter GAP.
REQ-015 In WAIT, i_mbus_rvalid=1 SHALL capture the result and enter GAP, with o_res_digits = DIGITS.
REQ-016 If i_mbus_rvalid does not arrive within TIMEOUT WAIT cycles, the block SHALL set o_res_cmp=000 and o_res_err=1, then enter GAP.
REQ-017 o_res_err SHALL also be set if the captured i_mbus_rdata is not exactly one-hot.
REQ-018 GAP SHALL hold wen=0 for GAP_CYCLES cycles and then enter HOLD.
REQ-019 In GAP, if i_mbus_rvalid is still 1 on the last GAP cycle, GAP SHALL extend until rvalid falls.
REQ-020 HOLD SHALL assert o_res_valid, keeping all o_res_* stable.
REQ-021 On i_res_ready in HOLD, the block SHALL return to IDLE; o_res_valid falls the next cycle.
REQ-022 i_res_ready=1 while o_res_valid=0 SHALL be ignored.
REQ-023 rvalid seen in IDLE or HOLD SHALL be ignored.
REQ-024 o_mbus_werr_limit SHALL be stable from the operand transfer through the end of GAP.
REQ-025 Counters SHALL be unsigned and saturate. The digit counter never exceeds DIGITS.
REQ-026 The timeout counter SHALL be clog2(TIMEOUT+1) bits wide.

Reset
REQ-027 Asserting i_rstn low SHALL asynchronously set the state to IDLE.
REQ-028 Reset SHALL zero all mbus outputs, o_res_cmp, o_res_digits, o_res_err and o_res_valid. o_op_ready SHALL be 1 after reset release.
REQ-029 Reset mid-STREAM SHALL drop wen within the same cycle. No partial result SHALL be presented after release.

Structure
REQ-030 A shared package/header SHALL hold:
- the digit encodings SD_PLUS1=2'b10 and SD_MINUS1=2'b01;
- the result codes CMP_GT=3'b100, CMP_EQ=3'b010 and CMP_LT=3'b001;
- the FSM state constants.
REQ-031 One sub-module SHALL be used: msdf_digit_shifter, a loadable left-shift register pair emitting the top digit each cycle.

Verification
REQ-032 DIGITS=4: x=8'h80, y=8'h00 -> 4 digits streamed with wlast on the 4th. Comparator model rdata=100 -> o_res_cmp=100, o_res_digits=4, o_res_err=0.
REQ-033 x=y=8'h5A -> o_res_cmp=010 after WAIT. GAP lasts exactly 2 cycles before o_res_valid.
REQ-034 Model asserts rvalid with rdata=001 after the 2nd digit -> wen drops the next cycle, o_res_digits=2, o_res_cmp=001.
REQ-035 Model never responds -> after 16 WAIT cycles o_res_err=1 and o_res_cmp=000. A further rdata=011 case -> o_res_err=1.
REQ-036 Reset pulsed on the 3rd STREAM cycle -> wen=0 immediately and o_res_valid=0. A new operand is accepted right after release.
REQ-037 i_res_ready held low for 10 cycles in HOLD -> outputs stable and o_op_ready=0. Back-to-back operands -> at least GAP_CYCLES wen-low cycles between bursts.
